// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers line/frame timing from active-low h_sync/v_sync
// sampled on pixel strobes, locks onto a stable raster and reports the
// active-window pixel coordinates.
module vga_sync_decoder #(
  parameter int unsigned HS_LEN  = 96,
  parameter int unsigned HBP     = 48,
  parameter int unsigned HACT    = 640,
  parameter int unsigned VS_LEN  = 2,
  parameter int unsigned VBP     = 33,
  parameter int unsigned VACT    = 480,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pix_stb,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        active,
  output logic        locked,
  output logic [15:0] line_len,
  output logic [15:0] frame_lines,
  output logic        new_frame,
  output logic        sync_err
);

  localparam logic [15:0] H_START  = 16'(HS_LEN + HBP);
  localparam logic [15:0] H_END    = 16'(HS_LEN + HBP + HACT - 1);
  localparam logic [15:0] V_START  = 16'(VS_LEN + VBP);
  localparam logic [15:0] V_END    = 16'(VS_LEN + VBP + VACT - 1);
  localparam logic [15:0] LOCK_MIN = 16'(VS_LEN + VBP + VACT);
  localparam logic [15:0] TMO      = 16'(TIMEOUT);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, vs_prev_q;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        frame_pend_q;
  logic [15:0] ref_len_q, ref_len_d;
  logic        ref_valid_q, ref_valid_d;
  logic        mismatch_q, mismatch_d;
  logic [15:0] line_len_q, frame_lines_q;
  logic [15:0] x_q, y_q;
  logic        active_q, new_frame_q, sync_err_q;

  logic        hs_fall, vs_fall, restart, timeout, len_bad, nf, err, act_d;
  logic [15:0] len_new, lines_inc;

  // Edge detection, counter next values and timeout detection
  always_comb begin
    hs_fall   = i_pix_stb & hs_prev_q & ~h_sync;
    vs_fall   = i_pix_stb & vs_prev_q & ~v_sync;
    // a v_sync edge coincident with an h_sync edge counts as already pending
    restart   = hs_fall & (frame_pend_q | vs_fall);
    len_new   = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 16'd1;
    // the line ending at this edge is included in the count
    lines_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 16'd1;
    h_cnt_d   = h_cnt_q;
    if (i_pix_stb) h_cnt_d = hs_fall ? '0 : len_new;
    line_cnt_d = restart ? '0 : (hs_fall ? lines_inc : line_cnt_q);
    timeout   = i_pix_stb & ~hs_fall & (h_cnt_q != TMO) & (h_cnt_d == TMO);
    len_bad   = ref_valid_q & (len_new != ref_len_q);
  end

  // Lock state machine next-state and event pulses
  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    ref_valid_d = ref_valid_q;
    mismatch_d  = mismatch_q;
    nf          = 1'b0;
    err         = 1'b0;
    if (i_pix_stb) begin
      unique case (state_q)
        SEARCH: begin
          if (restart) begin
            state_d     = MEASURE;
            mismatch_d  = 1'b0;
            ref_valid_d = 1'b0;
          end
        end
        MEASURE: begin
          if (timeout) begin
            state_d = SEARCH;
          end else if (restart) begin
            if (!mismatch_q && !len_bad && ref_valid_q && (lines_inc >= LOCK_MIN)) begin
              state_d = LOCKED;
              nf      = 1'b1;
            end
            mismatch_d  = 1'b0;
            ref_valid_d = 1'b0;
          end else if (hs_fall) begin
            if (!ref_valid_q) begin
              ref_len_d   = len_new;
              ref_valid_d = 1'b1;
            end else if (len_bad) begin
              mismatch_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (timeout || (hs_fall && (len_new != ref_len_q)) ||
              (restart && (lines_inc != frame_lines_q))) begin
            state_d = SEARCH;
            err     = 1'b1;
          end else if (restart) begin
            nf = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    act_d = (state_d == LOCKED) &&
            (h_cnt_d >= H_START) && (h_cnt_d <= H_END) &&
            (line_cnt_d >= V_START) && (line_cnt_d <= V_END);
  end

  // State, counters and registered outputs; updates only on strobe cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      line_cnt_q    <= '0;
      frame_pend_q  <= 1'b0;
      ref_len_q     <= '0;
      ref_valid_q   <= 1'b0;
      mismatch_q    <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      new_frame_q   <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      new_frame_q <= nf;
      sync_err_q  <= err;
      if (i_pix_stb) begin
        state_q     <= state_d;
        hs_prev_q   <= h_sync;
        vs_prev_q   <= v_sync;
        h_cnt_q     <= h_cnt_d;
        line_cnt_q  <= line_cnt_d;
        ref_len_q   <= ref_len_d;
        ref_valid_q <= ref_valid_d;
        mismatch_q  <= mismatch_d;
        if (restart)                 frame_pend_q <= 1'b0;
        else if (vs_fall)            frame_pend_q <= 1'b1;
        if (hs_fall)                 line_len_q    <= len_new;
        if (restart)                 frame_lines_q <= lines_inc;
        active_q <= act_d;
        x_q      <= act_d ? h_cnt_d - H_START : '0;
        y_q      <= act_d ? line_cnt_d - V_START : '0;
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign new_frame   = new_frame_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder on a scaled-down raster: 20 strobes per
// line (sync 4, back porch 3, active 10, front porch 3) and 10 lines per
// frame (sync 1, back porch 2, active 5, front porch 2); strobe every 4th clk.
module tb_vga_sync_decoder;

  localparam int HS  = 4;
  localparam int HB  = 3;
  localparam int HA  = 10;
  localparam int VS  = 1;
  localparam int VB  = 2;
  localparam int VA  = 5;
  localparam int TMO = 60;
  localparam int LL  = 20;
  localparam int FL  = 10;

  logic        clk;
  logic        reset;
  logic        i_pix_stb;
  logic        h_sync;
  logic        v_sync;
  logic [15:0] x;
  logic [15:0] y;
  logic        active;
  logic        locked;
  logic [15:0] line_len;
  logic [15:0] frame_lines;
  logic        new_frame;
  logic        sync_err;

  vga_sync_decoder #(
    .HS_LEN (HS),
    .HBP    (HB),
    .HACT   (HA),
    .VS_LEN (VS),
    .VBP    (VB),
    .VACT   (VA),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_pix_stb  (i_pix_stb),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .x          (x),
    .y          (y),
    .active     (active),
    .locked     (locked),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .new_frame  (new_frame),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit err;
    int lk;
    int ll;
    int fl;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void push(input bit err, input int lk, input int ll, input int fl);
    ev_t e;
    e.err = err;
    e.lk  = lk;
    e.ll  = ll;
    e.fl  = fl;
    exp_q.push_back(e);
  endfunction

  task automatic check_all(input string name, input int a, input int xx, input int yy,
                           input int lk, input int ll, input int fl);
    chk({name, ".active"},      int'(active),      a);
    chk({name, ".x"},           int'(x),           xx);
    chk({name, ".y"},           int'(y),           yy);
    chk({name, ".locked"},      int'(locked),      lk);
    chk({name, ".line_len"},    int'(line_len),    ll);
    chk({name, ".frame_lines"}, int'(frame_lines), fl);
    chk({name, ".new_frame"},   int'(new_frame),   0);
    chk({name, ".sync_err"},    int'(sync_err),    0);
  endtask

  // One pixel strobe: 1 clk with i_pix_stb high, then 3 idle clks
  task automatic strobe(input logic hs, input logic vs);
    h_sync    = hs;
    v_sync    = vs;
    i_pix_stb = 1'b1;
    @(negedge clk);
    i_pix_stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    chk("pre_reset.active", int'(active), 1);
    chk("pre_reset.x",      int'(x),      3);
    chk("pre_reset.y",      int'(y),      1);
    #2 reset = 1'b1;
    #1 check_all("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_line(input int l, input int len, input bit rst_here, input bit chk_act);
    for (int i = 0; i < len; i++) begin
      strobe((i < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
      if (chk_act) begin
        bit a;
        a = (i >= 7) && (i <= 16) && (l >= 3) && (l <= 7);
        chk("win.active", int'(active), int'(a));
        chk("win.x",      int'(x),      a ? i - 7 : 0);
        chk("win.y",      int'(y),      a ? l - 3 : 0);
      end
      if (rst_here && (i == 10)) do_reset();
    end
  endtask

  task automatic run_frame(input int short_line, input int rst_line, input bit chk_act);
    for (int l = 0; l < FL; l++)
      run_line(l, (l == short_line) ? LL - 1 : LL, l == rst_line, chk_act);
  endtask

  // Monitor: every new_frame/sync_err pulse pops one expected event
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (new_frame || sync_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({new_frame, sync_err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev.sync_err",    int'(sync_err),    int'(e.err));
          chk("ev.new_frame",   int'(new_frame),   int'(!e.err));
          chk("ev.locked",      int'(locked),      e.lk);
          chk("ev.line_len",    int'(line_len),    e.ll);
          chk("ev.frame_lines", int'(frame_lines), e.fl);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset     = 1'b1;
    i_pix_stb = 1'b0;
    h_sync    = 1'b1;
    v_sync    = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // A: first restart, SEARCH -> MEASURE
    run_frame(-1, -1, 1'b0);
    chk("after_A.locked", int'(locked), 0);
    // B: lock at second restart, then check the active window
    push(1'b0, 1, LL, FL);
    run_frame(-1, -1, 1'b1);
    // C: short line 4 -> error at line 5 edge
    push(1'b0, 1, LL, FL);
    push(1'b1, 0, LL - 1, FL);
    run_frame(4, -1, 1'b0);
    chk("after_C.locked", int'(locked), 0);
    // D: MEASURE; E0 relocks
    run_frame(-1, -1, 1'b0);
    push(1'b0, 1, LL, FL);
    run_line(0, LL, 1'b0, 1'b0);
    // hold h_sync high: h_cnt 19 -> 60 after 41 strobes
    push(1'b1, 0, LL, FL);
    repeat (50) strobe(1'b1, 1'b1);
    check_all("timeout", 0, 0, 0, 0, LL, FL);
    // F: SEARCH -> MEASURE; G0 locks, reset mid-active in line 4
    run_frame(-1, -1, 1'b0);
    push(1'b0, 1, LL, FL);
    run_frame(-1, 4, 1'b0);
    chk("after_G.locked", int'(locked), 0);
    // H: SEARCH -> MEASURE; I0 locks
    run_frame(-1, -1, 1'b0);
    chk("after_H.locked", int'(locked), 0);
    push(1'b0, 1, LL, FL);
    run_frame(-1, -1, 1'b0);
    check_all("pre_glitch", 0, 0, 0, 1, LL, FL);
    // toggle syncs without strobes: nothing may change
    for (int k = 0; k < 8; k++) begin
      h_sync = k[0];
      v_sync = k[1];
      @(negedge clk);
      check_all("no_strobe_toggle", 0, 0, 0, 1, LL, FL);
    end
    h_sync = 1'b1;
    v_sync = 1'b1;
    @(negedge clk);
    // J, K0: stays locked
    push(1'b0, 1, LL, FL);
    run_frame(-1, -1, 1'b0);
    push(1'b0, 1, LL, FL);
    run_line(0, LL, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("events_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter HS_LEN, default 96, meaning horizontal sync width in pixel strobes.
REQ-002 Parameter HBP, default 48, meaning horizontal back porch in pixel strobes.
REQ-003 Parameter HACT, default 640, meaning active pixels per line.
REQ-004 Parameter VS_LEN, default 2, meaning vertical sync width in lines.
REQ-005 Parameter VBP, default 33, meaning vertical back porch in lines.
REQ-006 Parameter VACT, default 480, meaning active lines per frame.
REQ-007 Parameter TIMEOUT, default 4095, meaning the strobe count without an h_sync edge that forces loss of lock.
REQ-008 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 Port i_pix_stb, input, 1 bit: pixel strobe; sampling and counting occur only in cycles where it is high.
REQ-011 Port h_sync, input, 1 bit: horizontal sync, active-low, synchronous to clk.
REQ-012 Port v_sync, input, 1 bit: vertical sync, active-low, synchronous to clk.
REQ-013 Port x, output, 16 bits: recovered active pixel column.
REQ-014 Port y, output, 16 bits: recovered active line.
REQ-015 Port active, output, 1 bit: current strobe lies in the active window while locked.
REQ-016 Port locked, output, 1 bit: timing is locked.
REQ-017 Port line_len, output, 16 bits: last measured strobes per line.
REQ-018 Port frame_lines, output, 16 bits: last measured lines per frame.
REQ-019 Port new_frame, output, 1 bit: one-clk pulse at frame start while locked.
REQ-020 Port sync_err, output, 1 bit: one-clk pulse when lock is lost.

Function
REQ-021 Edge detection: a registered copy of each sync is updated on strobe cycles only; a falling edge is prev=1 and current=0 in a strobe cycle.
REQ-022 h_cnt (16 bits) resets to 0 on an h_sync falling edge, otherwise increments by 1 per strobe, saturating at 0xFFFF.
REQ-023 At each h_sync falling edge: line_len <= h_cnt+1, and line_cnt increments (saturating at 0xFFFF).
REQ-024 A v_sync falling edge sets frame_pend; the next h_sync falling edge captures frame_lines <= line_cnt, sets line_cnt to 0 (not incremented), and clears frame_pend.
REQ-025 An h_sync edge and a v_sync edge in the same strobe cycle: the v_sync edge is treated as pending first, so that h_sync edge performs the frame restart.
REQ-026 State machine states: SEARCH, MEASURE, LOCKED.
REQ-027 SEARCH: on the first frame restart (REQ-024), go to MEASURE; clear the mismatch flag; clear the ref_valid flag.
REQ-028 MEASURE: the first line_len captured sets ref_len and ref_valid; any later line_len different from ref_len sets mismatch.
REQ-029 MEASURE: at the next frame restart, go to LOCKED if mismatch=0 and ref_valid=1 and frame_lines >= VS_LEN+VBP+VACT; otherwise stay in MEASURE with mismatch and ref_valid cleared.
REQ-030 LOCKED: a line_len different from ref_len, a captured frame_lines different from the previous frame's value, or h_cnt reaching TIMEOUT goes to SEARCH with a sync_err pulse.
REQ-031 In SEARCH or MEASURE, h_cnt reaching TIMEOUT goes to SEARCH with no sync_err pulse.
REQ-032 locked = (state==LOCKED); new_frame pulses for each frame restart performed in LOCKED, including the restart that enters LOCKED.
REQ-033 Active window: h_cnt in [HS_LEN+HBP, HS_LEN+HBP+HACT-1] and line_cnt in [VS_LEN+VBP, VS_LEN+VBP+VACT-1], while locked.
REQ-034 When active=1: x = h_cnt-(HS_LEN+HBP) and y = line_cnt-(VS_LEN+VBP).
REQ-035 When active=0: x = 0 and y = 0.
REQ-036 All outputs are registered and reflect a strobe cycle's evaluation one clk later.
REQ-037 All outputs hold their values when i_pix_stb=0.

Reset
REQ-038 While reset=1 (async): state=SEARCH; all counters, flags, and registers are 0; sync history is 1; outputs x=0, y=0, active=0, locked=0, line_len=0, frame_lines=0, new_frame=0, sync_err=0.
REQ-039 Reset asserted mid-frame aborts immediately; after release, lock requires the full SEARCH to MEASURE to LOCKED sequence again.

Verification
REQ-040 Standard 800x525 timing, strobe every 4th clk -> locked=1 at the second frame restart, line_len=800, frame_lines=525, new_frame pulses once per frame.
REQ-041 Locked stream -> active rises at h_cnt=144 with x=0, last active x=639, y runs 0..479 and starts at line_cnt=35.
REQ-042 While locked, inject one 799-strobe line -> one sync_err pulse, locked=0, state SEARCH, relock after two further clean frame restarts.
REQ-043 Hold h_sync high for 4095 strobes while locked -> sync_err pulse, locked=0, and x=y=active=0.
REQ-044 Assert reset mid-active line -> all outputs are 0 in the same cycle; with the stream continuing, relock follows the normal sequence.
REQ-045 Toggle h_sync/v_sync with i_pix_stb=0 -> no edges detected and no output changes.
